board_store: RTL and testbench

Parametrised single-clock game-board memory: X_SIZE×Y_SIZE cells of DATA_WIDTH bits. It has one write port, one enabled read port for game logic, and one free-running read port for the display renderer. Writes are read-modify-write, so a live count of cells holding COUNT_VAL is maintained; on the warships board this is the remaining ship cells. A clear sequencer fills the whole board after reset or on request. The block sits between the game FSM and the board-drawing pipeline.

---
 rtl/board_store_pkg.sv | 13 +
 rtl/board_store_ram.sv | 41 ++++
 rtl/board_store.sv | 173 +++++++++++++++++
 tb/tb_board_store.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_store_pkg.sv
// Shared types and helpers for the game-board store: cell encoding, sequencer states, addressing.
package board_store_pkg;

  typedef enum logic [1:0] {EMPTY = 2'd0, SHIP = 2'd1, HIT = 2'd2, MISS = 2'd3} cell_e;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} fsm_t;

  function automatic int unsigned lin_addr(input int unsigned x, input int unsigned y,
                                           input int unsigned x_size);
    return x + y * x_size;
  endfunction

endpackage

// File: rtl/board_store_ram.sv
// Board array: one write port, two registered read-first game/renderer ports and a
// registered read-first port feeding the old-value side of the read-modify-write.
module board_store_ram #(
  parameter int DEPTH = 144,
  parameter int AW    = 8,
  parameter int DW    = 2
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] raddr3,
  output logic [DW-1:0] rdata3
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1_q, rd2_q, rd3_q;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rd3_q <= '0;
    end else begin
      if (re1) rd1_q <= mem[raddr1];
      rd2_q <= mem[raddr2];
      rd3_q <= mem[raddr3];
    end

  assign rdata1 = rd1_q;
  assign rdata2 = rd2_q;
  assign rdata3 = rd3_q;
endmodule

// File: rtl/board_store.sv
// Game-board memory with clear sequencer, 2-stage RMW write pipe and live COUNT_VAL count.
// Optional range checking is enabled by defining BOARD_STORE_BOUNDS_CHECK_EN.
module board_store
  import board_store_pkg::*;
#(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int INIT_VAL     = 0,
  parameter int COUNT_VAL    = 1,
  localparam int CELLS  = X_SIZE * Y_SIZE,
  localparam int ADDR_W = $clog2(CELLS),
  localparam int CNT_W  = $clog2(CELLS + 1)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  input  logic [DATA_WIDTH-1:0]   clr_val,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [X_ADDR_WIDTH-1:0] wr_x,
  input  logic [Y_ADDR_WIDTH-1:0] wr_y,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd1_en,
  input  logic [X_ADDR_WIDTH-1:0] rd1_x,
  input  logic [Y_ADDR_WIDTH-1:0] rd1_y,
  output logic [DATA_WIDTH-1:0]   rd1_data,
  output logic                    rd1_valid,
  input  logic [X_ADDR_WIDTH-1:0] rd2_x,
  input  logic [Y_ADDR_WIDTH-1:0] rd2_y,
  output logic [DATA_WIDTH-1:0]   rd2_data,
  output logic [CNT_W-1:0]        count,
  output logic                    oob_err
);
  localparam logic [DATA_WIDTH-1:0] CV   = DATA_WIDTH'(COUNT_VAL);
  localparam logic [DATA_WIDTH-1:0] IV   = DATA_WIDTH'(INIT_VAL);
  localparam logic [ADDR_W-1:0]     LAST = ADDR_W'(CELLS - 1);

  fsm_t                  state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d, s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d, s1_data_q, s1_data_d, s1_fdata_q, s1_fdata_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  s1_vld_q, s1_vld_d, s1_fwd_q, s1_fwd_d, rd1_vld_q, rd1_vld_d;
  logic                  clr_acc, wr_ok, wr_acc, rd1_acc, wr_oob, cnt_inc, cnt_dec;
  logic [ADDR_W-1:0]     wr_addr, rd1_addr, rd2_addr, ram_waddr;
  logic [DATA_WIDTH-1:0] old_val, ram_wdata, ram_rd1, ram_rd2, ram_old;
  logic                  ram_we;

  assign wr_addr  = ADDR_W'(lin_addr(32'(wr_x),  32'(wr_y),  X_SIZE));
  assign rd1_addr = ADDR_W'(lin_addr(32'(rd1_x), 32'(rd1_y), X_SIZE));
  assign rd2_addr = ADDR_W'(lin_addr(32'(rd2_x), 32'(rd2_y), X_SIZE));

  assign busy    = (state_q == CLEAR);
  assign clr_acc = (state_q == IDLE) && clr_req;
  assign wr_ok   = wr_en && !busy && !clr_req;
  assign wr_acc  = wr_ok && !wr_oob;
  assign rd1_acc = rd1_en && !busy;

  // Stage 2's RAM read sampled before the stage-1 commit landed, so a
  // same-cell write one cycle ahead supplies the old value instead.
  assign old_val = s1_fwd_q ? s1_fdata_q : ram_old;
  assign cnt_inc = s1_vld_q && (s1_data_q == CV) && (old_val != CV);
  assign cnt_dec = s1_vld_q && (s1_data_q != CV) && (old_val == CV);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (clr_acc) begin
      state_d = CLEAR;
      ptr_d   = '0;
      fill_d  = clr_val;
    end else if (state_q == CLEAR) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST) begin
        state_d = IDLE;
        ptr_d   = '0;
        count_d = (fill_q == CV) ? CNT_W'(CELLS) : '0;
      end
    end
    if (cnt_inc)      count_d = count_q + CNT_W'(1);
    else if (cnt_dec) count_d = count_q - CNT_W'(1);
    s1_vld_d   = wr_acc;
    s1_addr_d  = wr_addr;
    s1_data_d  = wr_data;
    s1_fwd_d   = s1_vld_q && (s1_addr_q == wr_addr);
    s1_fdata_d = s1_data_q;
    rd1_vld_d  = rd1_acc;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      fill_q     <= IV;
      count_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_fwd_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_fdata_q <= '0;
      rd1_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      s1_vld_q   <= s1_vld_d;
      s1_fwd_q   <= s1_fwd_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_fdata_q <= s1_fdata_d;
      rd1_vld_q  <= rd1_vld_d;
    end

  // Sweep and stage-2 commit never share a cycle: clear waits for IDLE.
  assign ram_we    = busy || s1_vld_q;
  assign ram_waddr = busy ? ptr_q  : s1_addr_q;
  assign ram_wdata = busy ? fill_q : s1_data_q;

  board_store_ram #(.DEPTH(CELLS), .AW(ADDR_W), .DW(DATA_WIDTH)) u_ram (
    .clk(clk), .rst(rst),
    .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
    .re1(rd1_acc), .raddr1(rd1_addr), .rdata1(ram_rd1),
    .raddr2(rd2_addr), .rdata2(ram_rd2),
    .raddr3(wr_addr), .rdata3(ram_old)
  );

  assign count     = count_q;
  assign rd1_valid = rd1_vld_q;

`ifdef BOARD_STORE_BOUNDS_CHECK_EN
  localparam logic [X_ADDR_WIDTH:0] XLIM = (X_ADDR_WIDTH+1)'(X_SIZE);
  localparam logic [Y_ADDR_WIDTH:0] YLIM = (Y_ADDR_WIDTH+1)'(Y_SIZE);
  logic rd1_oob, rd2_oob, oob_q, oob_d, rd1_oob_q, rd1_oob_d, rd2_oob_q;

  assign wr_oob  = ({1'b0, wr_x}  >= XLIM) || ({1'b0, wr_y}  >= YLIM);
  assign rd1_oob = ({1'b0, rd1_x} >= XLIM) || ({1'b0, rd1_y} >= YLIM);
  assign rd2_oob = ({1'b0, rd2_x} >= XLIM) || ({1'b0, rd2_y} >= YLIM);

  always_comb begin
    oob_d     = clr_acc ? 1'b0
              : oob_q | (wr_ok && wr_oob) | (rd1_acc && rd1_oob) | rd2_oob;
    rd1_oob_d = rd1_acc ? rd1_oob : rd1_oob_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      oob_q     <= 1'b0;
      rd1_oob_q <= 1'b0;
      rd2_oob_q <= 1'b0;
    end else begin
      oob_q     <= oob_d;
      rd1_oob_q <= rd1_oob_d;
      rd2_oob_q <= rd2_oob;
    end

  assign oob_err  = oob_q;
  assign rd1_data = rd1_oob_q ? '0 : ram_rd1;
  assign rd2_data = rd2_oob_q ? '0 : ram_rd2;
`else
  assign wr_oob   = 1'b0;
  assign oob_err  = 1'b0;
  assign rd1_data = ram_rd1;
  assign rd2_data = ram_rd2;
`endif

  cnt_range_a: assert property (@(posedge clk) disable iff (rst)
    !(cnt_inc && count_q == CNT_W'(CELLS)) && !(cnt_dec && count_q == '0));
endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: cell-array model checked every cycle plus literal checkpoints.
module tb_board_store;
  localparam int N = 144;

  logic       clk = 1'b0, rst;
  logic       clr_req, wr_en, rd1_en, busy, rd1_valid, oob_err;
  logic [1:0] clr_val, wr_data, rd1_data, rd2_data;
  logic [3:0] wr_x, wr_y, rd1_x, rd1_y, rd2_x, rd2_y;
  logic [7:0] count;

  int tests = 0, fails = 0;

  board_store dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_val(clr_val), .busy(busy),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_x(rd1_x), .rd1_y(rd1_y), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .rd2_x(rd2_x), .rd2_y(rd2_y), .rd2_data(rd2_data), .count(count), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: board contents as plain array ----------------
  int m_mem [N];
  int m_ptr, m_fill, m_pa, m_pd, m_cnt, e_d1, e_d2;
  bit m_clr, m_pend, m_oob, e_v1, e_k1, e_k2;

  function automatic int lin(input int x, input int y);
    return x + y * 12;
  endfunction

  function automatic bit oob(input int x, input int y);
`ifdef BOARD_STORE_BOUNDS_CHECK_EN
    return (x >= 12) || (y >= 12);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ships();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_mem[i] == 1) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_mem[i] = -1;
      m_clr = 1; m_ptr = 0; m_fill = 0; m_pend = 0; m_cnt = 0; m_oob = 0;
      e_v1 = 0; e_d1 = 0; e_k1 = 1; e_d2 = 0; e_k2 = 1;
    end else begin
      automatic bit clr_pre = m_clr;
      automatic int x2 = int'(rd2_x), y2 = int'(rd2_y);
      automatic int x1 = int'(rd1_x), y1 = int'(rd1_y);
      automatic int xw = int'(wr_x),  yw = int'(wr_y);
      automatic bit set = oob(x2, y2);
      // reads see the array as it was before this edge's commit
      if (oob(x2, y2)) begin e_d2 = 0; e_k2 = 1; end
      else begin e_d2 = m_mem[lin(x2, y2)]; e_k2 = (e_d2 >= 0); end
      e_v1 = rd1_en && !clr_pre;
      if (e_v1) begin
        set |= oob(x1, y1);
        if (oob(x1, y1)) begin e_d1 = 0; e_k1 = 1; end
        else begin e_d1 = m_mem[lin(x1, y1)]; e_k1 = (e_d1 >= 0); end
      end
      if (!clr_pre && !clr_req && wr_en) set |= oob(xw, yw);
      if (m_pend) m_mem[m_pa] = m_pd;
      m_pend = 0;
      if (!clr_pre) begin
        m_cnt = ships();
        m_oob = clr_req ? 1'b0 : (m_oob | set);
        if (clr_req) begin m_clr = 1; m_ptr = 0; m_fill = int'(clr_val); end
        else if (wr_en && !oob(xw, yw)) begin
          m_pend = 1; m_pa = lin(xw, yw); m_pd = int'(wr_data);
        end
      end else begin
        m_oob |= set;
        m_mem[m_ptr] = m_fill;
        m_ptr++;
        if (m_ptr == N) begin m_clr = 0; m_cnt = ships(); end
      end
    end
    #1;
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_clr));
      chk("count", 32'(count), m_cnt);
      chk("rd1_valid", 32'(rd1_valid), 32'(e_v1));
      if (e_v1 && e_k1) chk("rd1_data", 32'(rd1_data), e_d1);
      if (e_k2) chk("rd2_data", 32'(rd2_data), e_d2);
      chk("oob_err", 32'(oob_err), 32'(m_oob));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input int x, input int y, input int d);
    wr_en = 1; wr_x = 4'(x); wr_y = 4'(y); wr_data = 2'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic rd1(input int x, input int y, input int exp, input string nm);
    rd1_en = 1; rd1_x = 4'(x); rd1_y = 4'(y);
    @(negedge clk);
    rd1_en = 0;
    chk(nm, 32'(rd1_data), exp);
    chk({nm, "_valid"}, 32'(rd1_valid), 1);
  endtask

  task automatic clr(input int v);
    clr_req = 1; clr_val = 2'(v);
    @(negedge clk);
    clr_req = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 1000);
    if (busy) chk("busy_timeout", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic sweep_rd2();
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 12; x++) begin
        rd2_x = 4'(x); rd2_y = 4'(y);
        @(negedge clk);
      end
  endtask

  initial begin
    int n;
    rst = 1; clr_req = 0; clr_val = 0; wr_en = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd1_en = 0; rd1_x = 0; rd1_y = 0; rd2_x = 0; rd2_y = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd1_valid", 32'(rd1_valid), 0);
    chk("rst_rd1_data", 32'(rd1_data), 0);
    chk("rst_rd2_data", 32'(rd2_data), 0);
    chk("rst_oob", 32'(oob_err), 0);
    rst = 0;

    wait_idle(n);
    chk("reset_busy_cycles", n, N);
    chk("reset_count", 32'(count), 0);
    sweep_rd2();
    chk("reset_rd2_11_11", 32'(rd2_data), 0);

    // single write, then a game read two idle cycles later
    wr(3, 2, 1);
    repeat (2) @(negedge clk);
    rd1(3, 2, 1, "rd1_3_2");
    @(negedge clk);
    chk("rd1_pulse_end", 32'(rd1_valid), 0);
    chk("count_after_ship", 32'(count), 1);

    // back-to-back same-cell writes exercise forwarding
    wr_en = 1; wr_x = 5; wr_y = 5; wr_data = 1;
    @(negedge clk); wr_data = 1;
    @(negedge clk); wr_data = 2;
    chk("fwd_count_a", 32'(count), 2);
    @(negedge clk); wr_en = 0;
    chk("fwd_count_b", 32'(count), 2);
    @(negedge clk);
    chk("fwd_count_c", 32'(count), 1);

    // clear to SHIP wins over a simultaneous write
    clr_req = 1; clr_val = 1; wr_en = 1; wr_x = 0; wr_y = 0; wr_data = 2;
    @(negedge clk);
    clr_req = 0; wr_en = 0;
    wait_idle(n);
    chk("clr_busy_cycles", n, N);
    chk("clr_count", 32'(count), N);
    rd1(0, 0, 1, "clr_wr_dropped");
    sweep_rd2();

    // renderer watches the last cell during a MISS clear
    rd2_x = 11; rd2_y = 11;
    clr(3);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rd2_data != 2'd3 && n < 400);
    chk("rd2_last_cell_cycle", n, N + 1);
    wait_idle(n);
    chk("miss_count", 32'(count), 0);

    // read on the commit edge returns the old value
    wr_en = 1; wr_x = 7; wr_y = 3; wr_data = 1;
    @(negedge clk);
    wr_en = 0; rd1_en = 1; rd1_x = 7; rd1_y = 3;
    @(negedge clk);
    chk("read_first_old", 32'(rd1_data), 3);
    @(negedge clk);
    rd1_en = 0;
    chk("read_first_new", 32'(rd1_data), 1);
    chk("read_first_count", 32'(count), 1);

`ifdef BOARD_STORE_BOUNDS_CHECK_EN
    wr(12, 0, 1);
    @(negedge clk);
    chk("oob_set", 32'(oob_err), 1);
    chk("oob_count", 32'(count), 1);
    rd1(0, 1, 3, "oob_wr_dropped");
    rd2_x = 12; rd2_y = 0;
    @(negedge clk);
    chk("oob_rd2_zero", 32'(rd2_data), 0);
    rd2_x = 11; rd2_y = 11;
    @(negedge clk);
    clr(0);
    chk("oob_cleared", 32'(oob_err), 0);
    wait_idle(n);
`else
    clr(0);
    wait_idle(n);
    chk("oob_tied", 32'(oob_err), 0);
`endif

    wr(0, 0, 1);
    wr(11, 11, 1);
    wr(0, 0, 3);
    @(negedge clk);
    chk("final_count", 32'(count), 1);
    rd1(11, 11, 1, "final_rd1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
